reg_wb_arbiter: RTL and testbench

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

---
 rtl/reg_wb_arbiter_pkg.sv | 12 +
 rtl/reg_wb_arbiter_if.sv | 40 ++++
 rtl/reg_wb_arbiter_scoreboard.sv | 42 ++++
 rtl/reg_wb_arbiter.sv | 119 +++++++++++
 tb/tb_reg_wb_arbiter.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/reg_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
package pcpu;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FORCE = 2'd2
  } arb_state_t;

  localparam int STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Bundle of pipeline writeback, MDU result, issue/decode and register-file write signals.
interface reg_wb_arbiter_if;

  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_stall;

  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;

  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        hazard_stall;

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  modport slave (
    input  wb_valid, wb_addr, wb_data,
    input  mdu_valid, mdu_addr, mdu_data,
    input  issue_valid, issue_addr, rs1_addr, rs2_addr,
    output wb_stall, mdu_ready, hazard_stall,
    output rf_we, rf_waddr, rf_wdata
  );

  modport master (
    output wb_valid, wb_addr, wb_data,
    output mdu_valid, mdu_addr, mdu_data,
    output issue_valid, issue_addr, rs1_addr, rs2_addr,
    input  wb_stall, mdu_ready, hazard_stall,
    input  rf_we, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/reg_wb_arbiter_scoreboard.sv
// Pending-destination scoreboard for in-flight MDU ops, with RAW/WAW hazard detection.
module reg_scoreboard (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue_valid,
  input  logic [4:0] issue_addr,
  input  logic       clr_valid,
  input  logic [4:0] clr_addr,
  input  logic [4:0] rs1_addr,
  input  logic [4:0] rs2_addr,
  output logic       hazard_stall
);

  logic [31:0] pending_reg;
  logic [31:0] pending_next;
  logic [31:0] set_vec;
  logic [31:0] clr_vec;

  // x0 is never tracked, so bit 0 stays clear for ever.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_decode
      assign set_vec[gi] = (gi != 0) && issue_valid && (issue_addr == 5'(gi));
      assign clr_vec[gi] = (gi != 0) && clr_valid && (clr_addr == 5'(gi));
    end
  endgenerate

  // A new issue to a register overrides a drain of the older result.
  assign pending_next = (pending_reg & ~clr_vec) | set_vec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  // Uses the registered view, so a register being cleared this cycle still stalls.
  assign hazard_stall = pending_reg[rs1_addr] || pending_reg[rs2_addr] ||
                        (issue_valid && pending_reg[issue_addr]);

endmodule

// File: rtl/reg_wb_arbiter.sv
// Shares the single register-file write port between pipeline writeback and a buffered MDU result.
module reg_wb_arbiter
  import pcpu::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input logic             clk,
  input logic             rst,
  reg_wb_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  arb_state_t       state_reg, state_next;
  logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;
  logic             buf_valid_reg;
  logic [4:0]       buf_addr_reg;
  logic [31:0]      buf_data_reg;

  logic wb_claim;
  logic accept;
  logic sel_wb;
  logic sel_buf;
  logic wb_stall_c;
  logic hazard_stall;

  assign wb_claim = bus.wb_valid && (bus.wb_addr != 5'd0);
  assign accept   = bus.mdu_valid && !buf_valid_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    starve_cnt_next = starve_cnt_reg;
    sel_wb          = 1'b0;
    sel_buf         = 1'b0;
    wb_stall_c      = 1'b0;
    case (state_reg)
      IDLE: begin
        sel_wb = wb_claim;
        if (accept) begin
          state_next      = HOLD;
          starve_cnt_next = '0;
        end
      end
      HOLD: begin
        if (wb_claim) begin
          sel_wb = 1'b1;
          if (starve_cnt_reg != CNT_MAX) begin
            starve_cnt_next = starve_cnt_reg + 1'b1;
          end
          if (starve_cnt_next == CNT_MAX) begin
            state_next = FORCE;
          end
        end else begin
          sel_buf         = 1'b1;
          starve_cnt_next = '0;
          state_next      = IDLE;
        end
      end
      FORCE: begin
        wb_stall_c      = 1'b1;
        sel_buf         = 1'b1;
        starve_cnt_next = '0;
        state_next      = IDLE;
      end
      default: begin
        state_next      = IDLE;
        starve_cnt_next = '0;
      end
    endcase
  end

  // Buffer contents are only meaningful while buf_valid_reg is set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid_reg <= 1'b0;
      buf_addr_reg  <= '0;
      buf_data_reg  <= '0;
    end else if (accept) begin
      buf_valid_reg <= 1'b1;
      buf_addr_reg  <= bus.mdu_addr;
      buf_data_reg  <= bus.mdu_data;
    end else if (sel_buf) begin
      buf_valid_reg <= 1'b0;
    end
  end

  // Write enable is masked during reset so a held WB request cannot leak a write.
  assign bus.rf_we     = !rst && (sel_wb || (sel_buf && (buf_addr_reg != 5'd0)));
  assign bus.rf_waddr  = sel_buf ? buf_addr_reg : bus.wb_addr;
  assign bus.rf_wdata  = sel_buf ? buf_data_reg : bus.wb_data;
  assign bus.wb_stall  = wb_stall_c;
  assign bus.mdu_ready = !buf_valid_reg;

  reg_scoreboard u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (bus.issue_valid),
    .issue_addr   (bus.issue_addr),
    .clr_valid    (sel_buf),
    .clr_addr     (buf_addr_reg),
    .rs1_addr     (bus.rs1_addr),
    .rs2_addr     (bus.rs2_addr),
    .hazard_stall (hazard_stall)
  );

  assign bus.hazard_stall = hazard_stall;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed and random checks of reg_wb_arbiter against a transaction-level model of the write port.
module tb_reg_wb_arbiter;

  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_wb_arbiter_if bus ();

  reg_wb_arbiter #(.STARVE_MAX(SMAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: one buffered result, how long it has waited, and which registers are in flight.
  bit          m_full;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_blocked;
  bit          m_pend[32];

  task automatic model_reset();
    m_full    = 0;
    m_addr    = '0;
    m_data    = '0;
    m_blocked = 0;
    for (int i = 0; i < 32; i++) m_pend[i] = 0;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(bit wv, logic [4:0] wa, logic [31:0] wd,
                       bit mv, logic [4:0] ma, logic [31:0] md,
                       bit iv, logic [4:0] ia, logic [4:0] r1, logic [4:0] r2);
    bus.wb_valid    = wv;  bus.wb_addr    = wa;  bus.wb_data  = wd;
    bus.mdu_valid   = mv;  bus.mdu_addr   = ma;  bus.mdu_data = md;
    bus.issue_valid = iv;  bus.issue_addr = ia;
    bus.rs1_addr    = r1;  bus.rs2_addr   = r2;
    #1;
  endtask

  // Checks the current inputs against the model, then advances one clock.
  task automatic cycle(string tag);
    bit force_now, claim, drain, accept, exp_we, hz;
    logic [4:0]  ea;
    logic [31:0] ed;
    force_now = m_full && (m_blocked >= SMAX);
    claim     = bus.wb_valid && (bus.wb_addr != 5'd0);
    drain     = 0;
    exp_we    = 0;
    ea        = '0;
    ed        = '0;
    if (force_now || (m_full && !claim)) begin
      drain  = 1;
      exp_we = (m_addr != 5'd0);
      ea     = m_addr;
      ed     = m_data;
    end else if (claim) begin
      exp_we = 1;
      ea     = bus.wb_addr;
      ed     = bus.wb_data;
    end
    hz = m_pend[bus.rs1_addr] || m_pend[bus.rs2_addr] ||
         (bus.issue_valid && m_pend[bus.issue_addr]);
    chk({tag, ".wb_stall"}, 32'(bus.wb_stall), 32'(force_now));
    chk({tag, ".mdu_ready"}, 32'(bus.mdu_ready), 32'(!m_full));
    chk({tag, ".rf_we"}, 32'(bus.rf_we), 32'(exp_we));
    chk({tag, ".hazard"}, 32'(bus.hazard_stall), 32'(hz));
    if (exp_we) begin
      chk({tag, ".waddr"}, 32'(bus.rf_waddr), 32'(ea));
      chk({tag, ".wdata"}, bus.rf_wdata, ed);
    end
    $display("[TB] %s wb=%0b/%0d mdu=%0b/%0d iss=%0b/%0d we=%0b waddr=%0d wdata=%0h stall=%0b hz=%0b",
             tag, bus.wb_valid, bus.wb_addr, bus.mdu_valid, bus.mdu_addr,
             bus.issue_valid, bus.issue_addr, bus.rf_we, bus.rf_waddr, bus.rf_wdata,
             bus.wb_stall, bus.hazard_stall);
    accept = !m_full && bus.mdu_valid;
    @(posedge clk);
    if (drain) begin
      m_full       = 0;
      m_blocked    = 0;
      m_pend[m_addr] = 0;
    end else if (m_full && claim && m_blocked < SMAX) begin
      m_blocked++;
    end
    if (accept) begin
      m_full    = 1;
      m_addr    = bus.mdu_addr;
      m_data    = bus.mdu_data;
      m_blocked = 0;
    end
    if (bus.issue_valid && bus.issue_addr != 5'd0) m_pend[bus.issue_addr] = 1;
    m_pend[0] = 0;
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    drive(1, 5'd3, 32'h1111, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("reset.mdu_ready", 32'(bus.mdu_ready), 32'd1);
    chk("reset.wb_stall", 32'(bus.wb_stall), 32'd0);
    chk("reset.hazard", 32'(bus.hazard_stall), 32'd0);
    chk("reset.rf_we", 32'(bus.rf_we), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // MDU result to x5 drains the next cycle and clears its pending bit.
    drive(0, 0, 0, 0, 0, 0, 1, 5'd5, 0, 0);                   cycle("issue5");
    drive(0, 0, 0, 1, 5'd5, 32'h1234, 0, 0, 0, 0);            cycle("mdu5");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5'd5, 0);
    chk("drain5.rf_we", 32'(bus.rf_we), 32'd1);
    chk("drain5.waddr", 32'(bus.rf_waddr), 32'd5);
    chk("drain5.wdata", bus.rf_wdata, 32'h1234);
    chk("drain5.hazard", 32'(bus.hazard_stall), 32'd1);
    cycle("drain5");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5'd5, 0);
    chk("after5.hazard", 32'(bus.hazard_stall), 32'd0);
    cycle("after5");

    // Starvation: four WB writes, one forced buffer write, then WB again.
    drive(0, 0, 0, 1, 5'd7, 32'hAAAA, 0, 0, 0, 0);            cycle("mdu7");
    for (int i = 0; i < 6; i++) begin
      drive(1, 5'd3, 32'(i), 0, 0, 0, 0, 0, 0, 0);
      chk($sformatf("starve%0d.wb_stall", i), 32'(bus.wb_stall), (i == 4) ? 32'd1 : 32'd0);
      chk($sformatf("starve%0d.waddr", i), 32'(bus.rf_waddr), (i == 4) ? 32'd7 : 32'd3);
      cycle($sformatf("starve%0d", i));
    end

    // Hazard on x9 persists until the buffer writes x9; a same-cycle re-issue keeps it pending.
    drive(0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 0);                   cycle("issue9");
    drive(0, 0, 0, 1, 5'd9, 32'h9999, 0, 0, 0, 5'd9);
    chk("mdu9.hazard", 32'(bus.hazard_stall), 32'd1);
    cycle("mdu9");
    drive(1, 5'd3, 32'h3, 0, 0, 0, 0, 0, 0, 5'd9);            cycle("block9");
    drive(0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 5'd9);
    chk("drain9.waddr", 32'(bus.rf_waddr), 32'd9);
    cycle("drain9_reissue");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd9);
    chk("reissue9.hazard", 32'(bus.hazard_stall), 32'd1);
    cycle("reissue9");
    drive(0, 0, 0, 1, 5'd9, 32'h9A9A, 0, 0, 0, 5'd9);         cycle("mdu9b");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd9);                   cycle("drain9b");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd9);
    chk("clear9.hazard", 32'(bus.hazard_stall), 32'd0);
    cycle("clear9");

    // Result to x0 is discarded but still empties the buffer.
    drive(0, 0, 0, 1, 5'd0, 32'h55, 0, 0, 0, 0);              cycle("mdu0");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("drain0.rf_we", 32'(bus.rf_we), 32'd0);
    cycle("drain0");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("after0.mdu_ready", 32'(bus.mdu_ready), 32'd1);
    cycle("after0");

    // Reset while holding a result drops it.
    drive(0, 0, 0, 1, 5'd12, 32'hBEEF, 0, 0, 0, 0);           cycle("mdu12");
    drive(1, 5'd3, 32'h33, 0, 0, 0, 0, 0, 0, 0);              cycle("hold12");
    rst = 1'b1;
    #1;
    chk("rsthold.rf_we", 32'(bus.rf_we), 32'd0);
    chk("rsthold.mdu_ready", 32'(bus.mdu_ready), 32'd1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("postrst.rf_we", 32'(bus.rf_we), 32'd0);
    cycle("postrst");

    // Random traffic on a narrow address range to force collisions and x0 cases.
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom(),
            $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)), $urandom(),
            $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      cycle($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
